// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, codeword bit positions and lane status for the SECDED decoder
package hamming_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;

  // Codeword layout, MSB to LSB: {q, d3, d2, d1, d0, p2, p1, p0}
  localparam int BIT_Q  = 7;
  localparam int BIT_D3 = 6;
  localparam int BIT_D2 = 5;
  localparam int BIT_D1 = 4;
  localparam int BIT_D0 = 3;
  localparam int BIT_P2 = 2;
  localparam int BIT_P1 = 1;
  localparam int BIT_P0 = 0;

  // Syndrome values that point at a data bit; the remaining non-zero values name parity bits
  localparam logic [2:0] SYN_D3 = 3'b111;
  localparam logic [2:0] SYN_D2 = 3'b110;
  localparam logic [2:0] SYN_D1 = 3'b101;
  localparam logic [2:0] SYN_D0 = 3'b011;

  typedef struct packed {
    logic corr;
    logic uncorr;
  } lane_status_t;

endpackage

// File: rtl/hamming_secded_lane.sv
// rtl/hamming_secded_lane.sv - combinational extended Hamming(8,4) decode of one lane
module hamming_secded_lane
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output lane_status_t      status
);

  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] flip;
  logic [2:0]        syn;
  logic              ovr;

  always_comb begin
    raw    = code[BIT_D3:BIT_D0];
    syn    = {code[BIT_P2] ^ code[BIT_D3] ^ code[BIT_D2] ^ code[BIT_D1],
              code[BIT_P1] ^ code[BIT_D3] ^ code[BIT_D2] ^ code[BIT_D0],
              code[BIT_P0] ^ code[BIT_D3] ^ code[BIT_D1] ^ code[BIT_D0]};
    ovr    = ^code;
    flip   = '0;
    data   = raw;
    status = '0;

    case (syn)
      SYN_D3:  flip = 4'b1000;
      SYN_D2:  flip = 4'b0100;
      SYN_D1:  flip = 4'b0010;
      SYN_D0:  flip = 4'b0001;
      default: flip = '0;
    endcase

    // Odd overall parity means a single flip somewhere; syndrome 0 means it hit q
    if (ovr) begin
      status.corr = 1'b1;
      data        = raw ^ flip;
    end else if (syn != 3'b000) begin
      status.uncorr = 1'b1;
    end
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - multi-lane SECDED decoder with one output register; counters under HAMMING_SECDED_ERR_CNT_EN
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CODE_W*LANES-1:0]   in_code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_corr,
  output logic [LANES-1:0]          out_uncorr,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          corr_cnt,
  output logic [CNT_W-1:0]          uncorr_cnt
);

  logic                    accept;
  logic [DATA_W*LANES-1:0] dec_data;
  logic [LANES-1:0]        dec_corr;
  logic [LANES-1:0]        dec_uncorr;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_status_t st;

    hamming_secded_lane u_lane (
      .code   (in_code[CODE_W*i +: CODE_W]),
      .data   (dec_data[DATA_W*i +: DATA_W]),
      .status (st)
    );

    assign dec_corr[i]   = st.corr;
    assign dec_uncorr[i] = st.uncorr;
  end

  // Decoded values are captured only on accept, so idle garbage on in_code never reaches the registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_corr   <= '0;
      out_uncorr <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= dec_data;
      out_corr   <= dec_corr;
      out_uncorr <= dec_uncorr;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef HAMMING_SECDED_ERR_CNT_EN
  localparam int              POP_W   = $clog2(LANES + 1);
  localparam int              SUM_W   = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int k = 0; k < LANES; k++) begin
      n = n + POP_W'(v[k]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [POP_W-1:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(n);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Clear takes priority, so events of a word accepted in the clear cycle are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (accept) begin
      corr_cnt   <= sat_add(corr_cnt, popcount(dec_corr));
      uncorr_cnt <= sat_add(uncorr_cnt, popcount(dec_uncorr));
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb/tb_hamming_secded_decoder.sv - directed self-checking bench for hamming_secded_decoder (LANES=2, CNT_W=2)
module tb_hamming_secded_decoder;

`ifdef HAMMING_SECDED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_corr;
  logic [1:0]  out_uncorr;
  logic        cnt_clr;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;

  int checks = 0;
  int errors = 0;
  int m_corr = 0;
  int m_unc  = 0;

  hamming_secded_decoder #(.LANES(2), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Saturating counter model, width 2
  task automatic model_acc(input int nc, input int nu, input bit clr);
    if (clr) begin
      m_corr = 0;
      m_unc  = 0;
    end else begin
      m_corr = (m_corr + nc > 3) ? 3 : m_corr + nc;
      m_unc  = (m_unc + nu > 3) ? 3 : m_unc + nu;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_corr_cnt"},   {30'd0, corr_cnt},   CNT_EN ? m_corr : 0);
    chk({tag, "_uncorr_cnt"}, {30'd0, uncorr_cnt}, CNT_EN ? m_unc  : 0);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] c, input logic [1:0] u);
    chk({tag, "_valid"},  {31'd0, out_valid}, 1);
    chk({tag, "_data"},   {24'd0, out_data},  {24'd0, d});
    chk({tag, "_corr"},   {30'd0, out_corr},  {30'd0, c});
    chk({tag, "_uncorr"}, {30'd0, out_uncorr}, {30'd0, u});
  endtask

  // One accepted word with out_ready high; sampled 1 ns after the capturing edge
  task automatic xfer(input logic [15:0] code, input bit clr);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    cnt_clr   = clr;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_code   = 16'hxxxx;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = 16'hxxxx; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  {31'd0, out_valid}, 0);
    chk("rst_data",   {24'd0, out_data},  0);
    chk("rst_corr",   {30'd0, out_corr},  0);
    chk("rst_uncorr", {30'd0, out_uncorr}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk_cnt("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean, single data error, q-only error, double error
    xfer(16'hD22D, 1'b0); model_acc(0, 0, 0);
    chk_out("clean", 8'hA5, 2'b00, 2'b00); chk_cnt("clean");
    xfer(16'h922D, 1'b0); model_acc(1, 0, 0);
    chk_out("l1_d3", 8'hA5, 2'b10, 2'b00); chk_cnt("l1_d3");
    xfer(16'hD2AD, 1'b0); model_acc(1, 0, 0);
    chk_out("l0_q", 8'hA5, 2'b01, 2'b00); chk_cnt("l0_q");
    xfer(16'hD22E, 1'b0); model_acc(0, 1, 0);
    chk_out("dbl", 8'hA5, 2'b00, 2'b01); chk_cnt("dbl");
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 0);

    // Backpressure: three words, out_ready low for four cycles after the first lands
    out_ready = 1'b0; in_valid = 1'b1; in_code = 16'h2DD2;
    @(posedge clk); #1; model_acc(0, 0, 0);
    in_code = 16'h922D;
    for (int k = 0; k < 4; k++) begin
      chk_out("bp_hold", 8'h5A, 2'b00, 2'b00);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    chk_out("bp_hold_last", 8'h5A, 2'b00, 2'b00);
    out_ready = 1'b1;
    @(posedge clk); #1; model_acc(1, 0, 0);
    chk_out("bp_w1", 8'hA5, 2'b10, 2'b00);
    in_code = 16'hD2AD;
    @(posedge clk); #1; model_acc(1, 0, 0);
    chk_out("bp_w2", 8'hA5, 2'b01, 2'b00);
    in_valid = 1'b0; in_code = 16'hxxxx;
    @(posedge clk); #1;
    chk("bp_drain", {31'd0, out_valid}, 0);
    chk_cnt("bp");

    // Clear wins over a simultaneous error word
    xfer(16'hD22E, 1'b1); model_acc(0, 1, 1);
    chk_out("clr_word", 8'hA5, 2'b00, 2'b01); chk_cnt("clr");

    // Saturation of the 2-bit uncorrectable counter
    for (int k = 0; k < 5; k++) begin
      xfer(16'hD22E, 1'b0); model_acc(0, 1, 0);
      if (k == 1) chk_cnt("sat_mid");
    end
    chk_cnt("sat_end");
    chk_out("sat_word", 8'hA5, 2'b00, 2'b01);

    // Asynchronous reset while a word is stalled at the output
    out_ready = 1'b0; in_valid = 1'b1; in_code = 16'hD22E;
    @(posedge clk); #1;
    in_valid = 1'b0; in_code = 16'hxxxx;
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2 rst = 1'b1; #1;
    model_acc(0, 0, 1);
    chk("arst_valid",  {31'd0, out_valid}, 0);
    chk("arst_data",   {24'd0, out_data},  0);
    chk("arst_uncorr", {30'd0, out_uncorr}, 0);
    chk_cnt("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    xfer(16'h922D, 1'b0); model_acc(1, 0, 0);
    chk_out("post_rst", 8'hA5, 2'b10, 2'b00); chk_cnt("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Multi-lane extended Hamming(8,4) SECDED decoder for the receive path, placed after the channel demodulator and ahead of the byte sink.
- Each lane corrects single-bit errors and detects double-bit errors on its own.
- Uses a valid/ready handshake with one registered output stage, and reports per-lane error flags plus optional saturating error counters.

Parameters:
- LANES, 2, number of 4-bit data lanes decoded in parallel (≥1).
- CNT_W, 16, width of each error counter (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept.
- in_code  in  8*LANES  codewords; lane i = in_code[8i+7:8i].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  4*LANES  decoded data; lane i = out_data[4i+3:4i].
- out_corr  out  LANES  per-lane flag: single error corrected.
- out_uncorr  out  LANES  per-lane flag: double error detected.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  corrected-lane event count.
- uncorr_cnt  out  CNT_W  uncorrectable-lane event count.

Behaviour:
- Lane codeword bit layout, MSB to LSB: {q, d3, d2, d1, d0, p2, p1, p0}.
  - p2 = d3^d2^d1, p1 = d3^d2^d0, p0 = d3^d1^d0.
  - q makes the XOR of all 8 bits equal to 0 (even parity).
- Syndrome s = {p2^d3^d2^d1, p1^d3^d2^d0, p0^d3^d1^d0}; overall check o = XOR of all 8 bits.
- Decode rules per lane:
  - s=0, o=0: clean.
  - s≠0, o=1: single error. Flip the bit named by s (111→d3, 110→d2, 101→d1, 011→d0; 100/010/001 are parity bits, so data is unchanged). Set corr.
  - s=0, o=1: error in q only. Data unchanged; set corr.
  - s≠0, o=0: double error. Output raw d3..d0; set uncorr.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - On accept, out_data/out_corr/out_uncorr/out_valid are registered next edge, so latency is 1 cycle.
  - If out_valid && out_ready and there is no accept, out_valid goes to 0 next cycle.
  - While out_valid && !out_ready, all outputs hold stable.
- Full throughput: back-to-back transfers with out_ready=1 give one word per cycle.
- Counters:
  - On each accept, each counter adds the popcount of the corresponding flag vector for that word.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - cnt_clr=1 forces both to 0 next edge. Clear wins over a simultaneous increment; that word's events are dropped.
- Reset (any time, including mid-transfer): out_valid=0, out_data=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0. Any in-flight word is discarded.
- in_code is ignored when in_valid=0; no X propagates into the registers.

Optional Feature:
- Macro HAMMING_SECDED_ERR_CNT_EN.
- Defined: counters are implemented as described above.
- Undefined: counter logic is removed; corr_cnt and uncorr_cnt are tied to 0 and cnt_clr is ignored. Ports remain so the interface is stable.

Decomposition:
- Shared package hamming_pkg holds:
  - localparams CODE_W=8 and DATA_W=4;
  - the syndrome-to-bit-position constants;
  - the lane status typedef {corr, uncorr}.
- One sub-module, hamming_secded_lane: purely combinational per-lane decode (code → data, corr, uncorr), instantiated LANES times with a generate loop.
- The top level owns the handshake register and the counters.

Test Plan (LANES=2 unless noted):
- Clean word: in_code=0xD22D → out_data=0xA5, out_corr=00, out_uncorr=00, 1 cycle after accept.
- Single data error: 0x922D (lane1 d3 flipped) → 0xA5, out_corr=10. 0xD2AD (lane0 q flipped) → 0xA5, out_corr=01. With the macro on, corr_cnt increments by 1 each time.
- Double error: 0xD22E (lane0 p1, p0 flipped) → out_data=0xA5, out_uncorr=01, out_corr=00, uncorr_cnt+1.
- Backpressure: stream 3 words while holding out_ready=0 for 4 cycles → first word holds stable, in_ready=0, no loss or duplication after release, order preserved.
- Saturation/clear with CNT_W=2: 5 double-error words → uncorr_cnt sticks at 3. cnt_clr asserted together with an error word → count 0.
- Reset asserted while out_valid=1 and out_ready=0 → all outputs 0 immediately. The next accepted word decodes correctly.
